// File: rtl/hls_run_ctrl_pkg.sv
// Shared types and constants for the Bambu accelerator run controller.
// Optional run watchdog is enabled with HLS_RUN_TIMEOUT_EN.
package hls_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        READ,
        REPORT
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;

    localparam int WORD_BYTES = 4;
    localparam int WORD_BITS  = 32;

endpackage

// File: rtl/hls_slave_access.sv
// Single-access engine for the accelerator slave port, channel 0 only.
// A request is held until DataRdy is sampled, then dropped the next cycle.
module hls_slave_access
    import hls_run_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [WORD_BITS-1:0]   wdata,
    output logic                   done,
    output logic [WORD_BITS-1:0]   rdata,
    output logic [1:0]             S_oe_ram,
    output logic [1:0]             S_we_ram,
    output logic [2*ADDR_W-1:0]    S_addr_ram,
    output logic [2*DATA_W-1:0]    S_Wdata_ram,
    output logic [2*SIZE_W-1:0]    S_data_ram_size,
    input  logic [2*DATA_W-1:0]    Sout_Rdata_ram,
    input  logic [1:0]             Sout_DataRdy
);

    logic                 active;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [WORD_BITS-1:0] wdata_q;
    logic                 unused_bits;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (req) begin
                    active  <= 1'b1;
                    we_q    <= we;
                    addr_q  <= addr;
                    wdata_q <= we ? wdata : '0;
                end
            end else if (Sout_DataRdy[0]) begin
                active  <= 1'b0;
                we_q    <= 1'b0;
                addr_q  <= '0;
                wdata_q <= '0;
                done    <= 1'b1;
                rdata   <= Sout_Rdata_ram[WORD_BITS-1:0];
            end
        end
    end

    // Channel 1 is never used; its half of every bus stays at zero.
    assign S_oe_ram        = {1'b0, active & ~we_q};
    assign S_we_ram        = {1'b0, active & we_q};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
    assign S_Wdata_ram     = {{(2*DATA_W-WORD_BITS){1'b0}}, wdata_q};
    assign S_data_ram_size = {{SIZE_W{1'b0}},
                              active ? SIZE_W'(WORD_BITS) : {SIZE_W{1'b0}}};

    assign unused_bits = ^{Sout_Rdata_ram[2*DATA_W-1:WORD_BITS],
                           Sout_DataRdy[1]};

endmodule

// File: rtl/hls_run_ctrl.sv
// Load / start / measure / read-back sequencer for a Bambu accelerator.
// Define HLS_RUN_TIMEOUT_EN to enable the cmd_timeout run watchdog.
module hls_run_ctrl
    import hls_run_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 7,
    parameter int CNT_W  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_base_addr,
    input  logic [CNT_W-1:0]     cmd_nwords,
    input  logic [CNT_W-1:0]     cmd_timeout,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [31:0]          ld_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [31:0]          rd_data,
    output logic                 acc_start_port,
    input  logic                 acc_done_port,
    output logic [1:0]           S_oe_ram,
    output logic [1:0]           S_we_ram,
    output logic [2*ADDR_W-1:0]  S_addr_ram,
    output logic [2*DATA_W-1:0]  S_Wdata_ram,
    output logic [2*SIZE_W-1:0]  S_data_ram_size,
    input  logic [2*DATA_W-1:0]  Sout_Rdata_ram,
    input  logic [1:0]           Sout_DataRdy,
    output logic                 busy,
    output logic                 status_valid,
    output logic [1:0]           status_code,
    output logic [CNT_W-1:0]     cycle_count
);

    state_t               state;
    logic [ADDR_W-1:0]    base_q;
    logic [CNT_W-1:0]     nwords_q;
    logic [CNT_W-1:0]     i_q;
    logic [CNT_W-1:0]     i_nxt;
    logic [CNT_W-1:0]     counter;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 pending;
    logic                 xfer_req;
    logic                 xfer_we;
    logic                 xfer_done;
    logic [ADDR_W-1:0]    xfer_addr;
    logic [WORD_BITS-1:0] xfer_rdata;

`ifdef HLS_RUN_TIMEOUT_EN
    logic [CNT_W-1:0]     tmo_q;
`else
    logic                 unused_tmo;
    assign unused_tmo = ^cmd_timeout;
`endif

    assign cmd_ready      = (state == IDLE);
    assign busy           = (state != IDLE);
    assign ld_ready       = (state == LOAD) && !pending;
    assign acc_start_port = (state == START);
    assign status_valid   = (state == REPORT);

    assign i_nxt   = i_q + 1'b1;
    assign cnt_inc = (&counter) ? counter : counter + 1'b1;

    // Word address wraps naturally at the slave address width.
    assign xfer_addr = base_q + (ADDR_W'(i_q) << $clog2(WORD_BYTES));
    assign xfer_we   = (state == LOAD);
    assign xfer_req  = ((state == LOAD) && ld_valid && !pending)
                     || ((state == READ) && !pending && !rd_valid);

    hls_slave_access #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W)
    ) u_access (
        .clock           (clock),
        .reset           (reset),
        .req             (xfer_req),
        .we              (xfer_we),
        .addr            (xfer_addr),
        .wdata           (ld_data),
        .done            (xfer_done),
        .rdata           (xfer_rdata),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            base_q      <= '0;
            nwords_q    <= '0;
            i_q         <= '0;
            counter     <= '0;
            pending     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            status_code <= ST_OK;
            cycle_count <= '0;
`ifdef HLS_RUN_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base_q   <= cmd_base_addr;
                        nwords_q <= cmd_nwords;
                        i_q      <= '0;
`ifdef HLS_RUN_TIMEOUT_EN
                        tmo_q    <= cmd_timeout;
`endif
                        state    <= (cmd_nwords == '0) ? START : LOAD;
                    end
                end
                LOAD: begin
                    if (xfer_req) begin
                        pending <= 1'b1;
                    end
                    if (xfer_done) begin
                        pending <= 1'b0;
                        i_q     <= i_nxt;
                        if (i_nxt == nwords_q) begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    counter <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    counter <= cnt_inc;
                    if (acc_done_port) begin
                        cycle_count <= cnt_inc;
                        status_code <= ST_OK;
                        i_q         <= '0;
                        state       <= (nwords_q != '0) ? READ : REPORT;
                    end
`ifdef HLS_RUN_TIMEOUT_EN
                    else if (tmo_q != '0 && cnt_inc == tmo_q) begin
                        cycle_count <= tmo_q;
                        status_code <= ST_TIMEOUT;
                        state       <= REPORT;
                    end
`endif
                end
                READ: begin
                    if (xfer_req) begin
                        pending <= 1'b1;
                    end
                    if (xfer_done) begin
                        pending  <= 1'b0;
                        rd_valid <= 1'b1;
                        rd_data  <= xfer_rdata;
                    end
                    if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        i_q      <= i_nxt;
                        if (i_nxt == nwords_q) begin
                            state <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_run_ctrl.sv
// Randomized bench for hls_run_ctrl with memory, accelerator and stream models.
// Timeout behaviour is checked per HLS_RUN_TIMEOUT_EN.
module tb_hls_run_ctrl;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [9:0]   cmd_base_addr = '0;
    logic [31:0]  cmd_nwords = '0;
    logic [31:0]  cmd_timeout = '0;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [31:0]  ld_data = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [31:0]  rd_data;
    logic         acc_start_port;
    logic         acc_done_port = 1'b0;
    logic [1:0]   S_oe_ram;
    logic [1:0]   S_we_ram;
    logic [19:0]  S_addr_ram;
    logic [127:0] S_Wdata_ram;
    logic [13:0]  S_data_ram_size;
    logic [127:0] Sout_Rdata_ram = '0;
    logic [1:0]   Sout_DataRdy = '0;
    logic         busy;
    logic         status_valid;
    logic [1:0]   status_code;
    logic [31:0]  cycle_count;

    hls_run_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_base_addr   (cmd_base_addr),
        .cmd_nwords      (cmd_nwords),
        .cmd_timeout     (cmd_timeout),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_data         (ld_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .acc_start_port  (acc_start_port),
        .acc_done_port   (acc_done_port),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy),
        .busy            (busy),
        .status_valid    (status_valid),
        .status_code     (status_code),
        .cycle_count     (cycle_count)
    );

    always #5 clock = ~clock;

    localparam int BUDGET = 3000;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 1;
    int acc_delay = -1;
    int rd_mode = 0;
    int cur_base = 0;
    int cur_n = 0;
    int age = 0;
    int hold_len = 0;
    int hold_bad = 0;
    int overlap = 0;
    int bus_bad = 0;
    int status_pulses = 0;
    int acc_starts = 0;
    int stuck = 0;
    logic [1:0]  got_code = '0;
    logic [31:0] got_cycles = '0;
    logic [31:0] mem [0:255];
    logic [31:0] ld_q [$];
    int          wr_addrs [$];
    logic [63:0] wr_data [$];
    int          rd_addrs [$];
    logic [31:0] rd_words [$];

    task automatic sort_region();
        logic [31:0] q [$];
        for (int k = 0; k < cur_n; k++)
            q.push_back(mem[((cur_base + 4 * k) % 1024) / 4]);
        q.sort();
        for (int k = 0; k < cur_n; k++)
            mem[((cur_base + 4 * k) % 1024) / 4] = q[k];
    endtask

    // Slave memory with fixed access latency, plus readback backpressure.
    always @(posedge clock) begin
        #1;
        case (rd_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = ~rd_ready;
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
        Sout_DataRdy   = 2'b00;
        Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
        if (S_oe_ram[0] || S_we_ram[0]) begin
            age++;
            if (age == mem_lat) begin
                Sout_DataRdy = 2'b01;
                if (S_we_ram[0]) mem[S_addr_ram[9:2]] = S_Wdata_ram[31:0];
                else Sout_Rdata_ram[31:0] = mem[S_addr_ram[9:2]];
            end
        end else begin
            age = 0;
        end
    end

    // Accelerator: sorts the buffer and raises done acc_delay cycles after start.
    always @(negedge clock) begin
        if (reset && acc_start_port) begin
            acc_starts++;
            if (acc_delay > 0) begin
                repeat (acc_delay) @(posedge clock);
                #1;
                sort_region();
                acc_done_port = 1'b1;
                @(posedge clock);
                #1;
                acc_done_port = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            if (S_oe_ram[0] && S_we_ram[0]) overlap++;
            if (S_oe_ram[1] || S_we_ram[1] || S_addr_ram[19:10] != 0
                || S_Wdata_ram[127:64] != 0 || S_data_ram_size[13:7] != 0)
                bus_bad++;
            if (S_oe_ram[0] || S_we_ram[0]) begin
                if (hold_len == 0) begin
                    if (S_we_ram[0]) begin
                        wr_addrs.push_back(int'(S_addr_ram[9:0]));
                        wr_data.push_back(S_Wdata_ram[63:0]);
                    end else begin
                        rd_addrs.push_back(int'(S_addr_ram[9:0]));
                    end
                    if (S_data_ram_size[6:0] != 7'd32) bus_bad++;
                end
                hold_len++;
            end else if (hold_len != 0) begin
                if (hold_len != mem_lat) hold_bad++;
                hold_len = 0;
            end
            if (rd_valid && rd_ready) rd_words.push_back(rd_data);
            if (status_valid) begin
                status_pulses++;
                got_code   = status_code;
                got_cycles = cycle_count;
            end
        end else begin
            hold_len = 0;
        end
    end

    // Drives one command and its preload words (from ld_q); no checking here.
    task automatic do_run(input int base, input int n, input int acc,
                          input int mlat, input int rmode, input int tmo,
                          input bit expect_end, input int extra);
        int w;
        wr_addrs.delete(); wr_data.delete();
        rd_addrs.delete(); rd_words.delete();
        status_pulses = 0; hold_bad = 0; overlap = 0; bus_bad = 0;
        stuck = 0; acc_starts = 0;
        mem_lat = mlat; acc_delay = acc; rd_mode = rmode;
        cur_base = base; cur_n = n;
        w = 0;
        while (!cmd_ready && w < BUDGET) begin @(posedge clock); #1; w++; end
        if (w >= BUDGET) stuck++;
        cmd_valid = 1'b1;
        cmd_base_addr = 10'(base);
        cmd_nwords = 32'(n);
        cmd_timeout = 32'(tmo);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clock); #1; end
            ld_valid = 1'b1;
            ld_data = ld_q[k];
            w = 0;
            while (!ld_ready && w < BUDGET) begin @(posedge clock); #1; w++; end
            if (w >= BUDGET) stuck++;
            @(posedge clock); #1;
            ld_valid = 1'b0;
            ld_data = $urandom;
        end
        if (expect_end) begin
            w = 0;
            while (status_pulses == 0 && w < BUDGET) begin @(posedge clock); #1; w++; end
            if (w >= BUDGET) stuck++;
            repeat (3) begin @(posedge clock); #1; end
        end else begin
            repeat (extra) begin @(posedge clock); #1; end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if ({S_oe_ram, S_we_ram} !== 4'b0) begin n_bad++; $display("FAIL reset_oe_we: got %0h want 0", {S_oe_ram, S_we_ram}); end
        n_cmp++; if ({ld_ready, rd_valid, acc_start_port, status_valid} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %0h want 0", {ld_ready, rd_valid, acc_start_port, status_valid}); end
        n_cmp++; if ({cycle_count, status_code} !== 34'b0) begin n_bad++; $display("FAIL reset_status: got %0h want 0", {cycle_count, status_code}); end
    endtask

    task automatic test_load_run();
        logic [31:0] want [$];
        ld_q = '{32'd9, 32'd3, 32'd7, 32'd1};
        want = '{32'd1, 32'd3, 32'd7, 32'd9};
        do_run(32'h040, 4, 20, 1, 0, 100, 1'b1, 0);
        n_cmp++; if (stuck !== 0) begin n_bad++; $display("FAIL load_run_budget: got %0d want 0", stuck); end
        n_cmp++; if (wr_addrs.size() !== 4 || rd_words.size() !== 4) begin n_bad++; $display("FAIL load_run_counts: got %0d/%0d want 4/4", wr_addrs.size(), rd_words.size()); end
        for (int k = 0; k < 4 && k < wr_addrs.size(); k++) begin
            n_cmp++; if (wr_addrs[k] !== 32'h040 + 4 * k) begin n_bad++; $display("FAIL load_run_waddr%0d: got %0h want %0h", k, wr_addrs[k], 32'h040 + 4 * k); end
            n_cmp++; if (wr_data[k] !== {32'b0, ld_q[k]}) begin n_bad++; $display("FAIL load_run_wdata%0d: got %0h want %0h", k, wr_data[k], ld_q[k]); end
        end
        for (int k = 0; k < 4 && k < rd_words.size(); k++) begin
            n_cmp++; if (rd_words[k] !== want[k]) begin n_bad++; $display("FAIL load_run_rd%0d: got %0d want %0d", k, rd_words[k], want[k]); end
        end
        n_cmp++; if (got_cycles !== 32'd20) begin n_bad++; $display("FAIL load_run_cycles: got %0d want 20", got_cycles); end
        n_cmp++; if (got_code !== 2'd0) begin n_bad++; $display("FAIL load_run_code: got %0d want 0", got_code); end
        n_cmp++; if (status_pulses !== 1) begin n_bad++; $display("FAIL load_run_pulses: got %0d want 1", status_pulses); end
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL load_run_idle: got %0b%0b want 10", cmd_ready, busy); end
    endtask

    task automatic test_zero_words();
        ld_q.delete();
        do_run(32'h100, 0, 1, 1, 0, 0, 1'b1, 0);
        n_cmp++; if (wr_addrs.size() + rd_addrs.size() !== 0) begin n_bad++; $display("FAIL zero_access: got %0d want 0", wr_addrs.size() + rd_addrs.size()); end
        n_cmp++; if (got_cycles !== 32'd1) begin n_bad++; $display("FAIL zero_cycles: got %0d want 1", got_cycles); end
        n_cmp++; if (status_pulses !== 1 || got_code !== 2'd0) begin n_bad++; $display("FAIL zero_status: got %0d/%0d want 1/0", status_pulses, got_code); end
    endtask

    task automatic test_backpressure();
        logic [31:0] want [$];
        ld_q.delete();
        for (int k = 0; k < 6; k++) ld_q.push_back($urandom);
        want = ld_q;
        want.sort();
        do_run(32'h200, 6, 12, 3, 1, 0, 1'b1, 0);
        n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d bad holds want 0", hold_bad); end
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL bp_overlap: got %0d want 0", overlap); end
        n_cmp++; if (bus_bad !== 0) begin n_bad++; $display("FAIL bp_bus: got %0d want 0", bus_bad); end
        n_cmp++; if (rd_words.size() !== 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", rd_words.size()); end
        for (int k = 0; k < 6 && k < rd_words.size(); k++) begin
            n_cmp++; if (rd_words[k] !== want[k]) begin n_bad++; $display("FAIL bp_rd%0d: got %0h want %0h", k, rd_words[k], want[k]); end
        end
    endtask

    task automatic test_wrap();
        ld_q = '{32'h5, 32'h2};
        do_run(32'h3FC, 2, 5, 2, 2, 0, 1'b1, 0);
        n_cmp++; if (wr_addrs.size() !== 2 || rd_addrs.size() !== 2) begin n_bad++; $display("FAIL wrap_counts: got %0d/%0d want 2/2", wr_addrs.size(), rd_addrs.size()); end
        else begin
            n_cmp++; if (wr_addrs[0] !== 32'h3FC || wr_addrs[1] !== 0) begin n_bad++; $display("FAIL wrap_waddr: got %0h,%0h want 3fc,0", wr_addrs[0], wr_addrs[1]); end
            n_cmp++; if (rd_addrs[0] !== 32'h3FC || rd_addrs[1] !== 0) begin n_bad++; $display("FAIL wrap_raddr: got %0h,%0h want 3fc,0", rd_addrs[0], rd_addrs[1]); end
        end
        n_cmp++; if (rd_words.size() !== 2 || rd_words[0] !== 32'h2 || rd_words[1] !== 32'h5) begin n_bad++; $display("FAIL wrap_rd: got %0d words want 2,5", rd_words.size()); end
    endtask

    task automatic test_timeout();
        ld_q = '{32'd4, 32'd8, 32'd6};
`ifdef HLS_RUN_TIMEOUT_EN
        do_run(32'h080, 3, -1, 1, 0, 50, 1'b1, 0);
        n_cmp++; if (got_code !== 2'd1) begin n_bad++; $display("FAIL tmo_code: got %0d want 1", got_code); end
        n_cmp++; if (got_cycles !== 32'd50) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 50", got_cycles); end
        n_cmp++; if (rd_addrs.size() + rd_words.size() !== 0) begin n_bad++; $display("FAIL tmo_readback: got %0d want 0", rd_addrs.size() + rd_words.size()); end
        n_cmp++; if (status_pulses !== 1) begin n_bad++; $display("FAIL tmo_pulses: got %0d want 1", status_pulses); end
`else
        do_run(32'h080, 3, -1, 1, 0, 50, 1'b0, 200);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL notmo_busy: got %0b want 1", busy); end
        n_cmp++; if (status_pulses !== 0 || rd_addrs.size() !== 0) begin n_bad++; $display("FAIL notmo_end: got %0d/%0d want 0/0", status_pulses, rd_addrs.size()); end
        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
`endif
    endtask

    task automatic test_reset_in_run();
        ld_q = '{32'h11, 32'h22};
        do_run(32'h100, 2, -1, 2, 0, 0, 1'b0, 12);
        n_cmp++; if (acc_starts !== 1 || busy !== 1'b1) begin n_bad++; $display("FAIL rir_running: got %0d/%0b want 1/1", acc_starts, busy); end
        #3 reset = 1'b0;
        #1;
        n_cmp++; if ({busy, ld_ready, rd_valid, acc_start_port, status_valid} !== 5'b0) begin n_bad++; $display("FAIL rir_flags: got %0h want 0", {busy, ld_ready, rd_valid, acc_start_port, status_valid}); end
        n_cmp++; if ({S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size} !== 38'b0 || S_Wdata_ram !== 128'b0) begin n_bad++; $display("FAIL rir_bus: got %0h want 0", {S_oe_ram, S_we_ram, S_addr_ram}); end
        n_cmp++; if ({cycle_count, status_code, rd_data} !== 66'b0) begin n_bad++; $display("FAIL rir_regs: got %0h want 0", {cycle_count, status_code}); end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rir_release: got %0b%0b want 10", cmd_ready, busy); end
        n_cmp++; if (status_pulses !== 0) begin n_bad++; $display("FAIL rir_pulse: got %0d want 0", status_pulses); end
    endtask

    task automatic test_random();
        logic [31:0] want [$];
        int base, n, acc;
        for (int r = 0; r < 5; r++) begin
            base = 4 * int'($urandom_range(0, 255));
            n = int'($urandom_range(1, 8));
            acc = int'($urandom_range(1, 30));
            ld_q.delete();
            for (int k = 0; k < n; k++) ld_q.push_back($urandom);
            want = ld_q;
            want.sort();
            do_run(base, n, acc, int'($urandom_range(1, 4)), 2,
                   acc + int'($urandom_range(1, 60)), 1'b1, 0);
            n_cmp++; if (stuck !== 0 || hold_bad !== 0 || overlap !== 0 || bus_bad !== 0) begin n_bad++; $display("FAIL rand%0d_protocol: got %0d/%0d/%0d/%0d want 0", r, stuck, hold_bad, overlap, bus_bad); end
            n_cmp++; if (wr_addrs.size() !== n || rd_words.size() !== n) begin n_bad++; $display("FAIL rand%0d_counts: got %0d/%0d want %0d", r, wr_addrs.size(), rd_words.size(), n); end
            for (int k = 0; k < n && k < wr_addrs.size() && k < rd_words.size(); k++) begin
                n_cmp++; if (wr_addrs[k] !== (base + 4 * k) % 1024 || wr_data[k] !== {32'b0, ld_q[k]}) begin n_bad++; $display("FAIL rand%0d_wr%0d: got %0h/%0h want %0h/%0h", r, k, wr_addrs[k], wr_data[k], (base + 4 * k) % 1024, ld_q[k]); end
                n_cmp++; if (rd_words[k] !== want[k]) begin n_bad++; $display("FAIL rand%0d_rd%0d: got %0h want %0h", r, k, rd_words[k], want[k]); end
            end
            n_cmp++; if (got_cycles !== 32'(acc) || got_code !== 2'd0 || status_pulses !== 1) begin n_bad++; $display("FAIL rand%0d_status: got %0d/%0d/%0d want %0d/0/1", r, got_cycles, got_code, status_pulses, acc); end
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = '0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        test_load_run();
        test_zero_words();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_reset_in_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hls_run_ctrl.md
Name: hls_run_ctrl

Overview:
- Sequences one run of a Bambu-generated accelerator, such as the bsort100 `main`, through its slave memory port and its start_port/done_port pair.
- Run order: preload N 32-bit words into accelerator memory, pulse start, count cycles until done, read the same region back, emit it as a stream, report status.
- Synthesizable replacement for the simulation-only load/start/measure flow, so hardware runs can be driven from a host FIFO.
- Drives slave channel 0 only; channel-1 slave bits are tied to 0.

Parameters:
- ADDR_W, 10: per-channel slave byte-address width.
- DATA_W, 64: per-channel slave data width.
- SIZE_W, 7: per-channel data_ram_size width.
- CNT_W, 32: width of the cycle counter, the timeout field and the word count.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  run command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_base_addr  in  ADDR_W  byte base address of the buffer.
- cmd_nwords  in  CNT_W  number of 32-bit words to load and to read back.
- cmd_timeout  in  CNT_W  run watchdog limit in cycles (optional feature).
- ld_valid/ld_ready  in/out  1  preload word stream handshake.
- ld_data  in  32  preload word.
- rd_valid/rd_ready  out/in  1  readback word stream handshake.
- rd_data  out  32  readback word.
- acc_start_port  out  1  one-cycle start pulse to the accelerator.
- acc_done_port  in  1  accelerator done.
- S_oe_ram  out  2  read request, channel 0 = bit 0.
- S_we_ram  out  2  write request, channel 0 = bit 0.
- S_addr_ram  out  2*ADDR_W  slave address.
- S_Wdata_ram  out  2*DATA_W  slave write data.
- S_data_ram_size  out  2*SIZE_W  access size in bits.
- Sout_Rdata_ram  in  2*DATA_W  slave read data.
- Sout_DataRdy  in  2  access complete, channel 0 = bit 0.
- busy  out  1  high in any state other than IDLE.
- status_valid  out  1  one-cycle pulse at the end of a run.
- status_code  out  2  0 = ok, 1 = timeout; 2 and 3 reserved.
- cycle_count  out  CNT_W  measured run cycles; held until the next run.

Behaviour:
- Reset values: every output 0, except cmd_ready = 1; state = IDLE. Asserting reset mid-run aborts immediately with no status pulse.
- IDLE:
  - On cmd_valid, latch base, nwords and timeout; clear the index i.
  - Go to LOAD, or to START if nwords == 0.
- LOAD:
  - ld_ready = 1 when no slave access is outstanding.
  - On each ld handshake, issue a write: S_we_ram[0] = 1, addr = base + 4*i (modulo 2^ADDR_W), Wdata[31:0] = ld_data with upper bits 0, size = 32.
  - Hold the request until Sout_DataRdy[0] is sampled high; deassert it the next cycle and increment i.
  - After the nwords-th write completes, go to START.
- START:
  - acc_start_port = 1 for exactly one cycle; the counter is cleared to 0. Go to RUN.
- RUN:
  - Counter increments every cycle.
  - When acc_done_port is sampled high: cycle_count = counter + 1. If done is seen in the first RUN cycle, cycle_count = 1.
  - If nwords != 0, clear i and go to READ; otherwise go to REPORT.
  - acc_done_port is ignored outside RUN.
- READ:
  - Issue a read: S_oe_ram[0] = 1 at the same addresses as LOAD, held until DataRdy.
  - Capture Sout_Rdata_ram[31:0] into rd_data and raise rd_valid.
  - rd_valid stays high until rd_ready; no new read is issued while rd_valid is high.
  - After the nwords-th word is accepted, go to REPORT.
- REPORT:
  - status_valid = 1 for one cycle, then return to IDLE.
- we and oe are never high in the same cycle.
- Slave access latency is unbounded; the controller never times out a single access.
- The counter saturates at all-ones rather than wrapping.

Optional Feature:
- Macro HLS_RUN_TIMEOUT_EN.
- Defined:
  - In RUN, when the counter reaches cmd_timeout (with cmd_timeout != 0) before done, set status_code = 1 and cycle_count = cmd_timeout.
  - Skip READ and go straight to REPORT.
  - cmd_timeout == 0 disables the watchdog.
- Undefined:
  - cmd_timeout is ignored; RUN waits forever; status_code is always 0.

Decomposition:
- Package hls_run_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, START, RUN, READ, REPORT);
  - status codes ST_OK and ST_TIMEOUT;
  - WORD_BYTES = 4 and WORD_BITS = 32.
- One sub-module, hls_slave_access:
  - single-access engine with req/we/addr/wdata inputs and done/rdata outputs;
  - owns the hold-until-DataRdy logic and the channel-0 bit packing.

Test Plan:
- Load, run and read 4 words: nwords = 4, base = 0x040, words 9, 3, 7, 1; accelerator model sorts and raises done 20 cycles after start.
  Required: writes land at 0x040, 0x044, 0x048, 0x04C; rd stream returns 1, 3, 7, 9; cycle_count = 20; status_code = 0; one status_valid pulse.
- nwords = 0 with done returned 1 cycle after start.
  Required: no slave access; cycle_count = 1; status_valid follows.
- Backpressure with DataRdy delayed 3 cycles and rd_ready toggled every other cycle.
  Required: each request is held exactly 3 cycles; no word lost or duplicated; oe and we never both high.
- Address wrap: base = 0x3FC, nwords = 2.
  Required: addresses 0x3FC then 0x000.
- HLS_RUN_TIMEOUT_EN with cmd_timeout = 50 and done never asserted.
  Required: status_code = 1; cycle_count = 50; no readback. Without the macro: busy stays high.
- Reset dropped low during RUN.
  Required: all outputs 0 asynchronously; cmd_ready = 1 after reset is released; no status_valid pulse.
